// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO one entry at a time and serialises each
// byte as a UART frame (start, 8 data bits LSB first, optional even parity,
// one stop bit). The read strobe is issued in REQ; the FIFO's registered read
// data is captured in LOAD, the following cycle.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_enb,
  output logic       fifo_rd_reg,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             rd_q, rd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_end;
  logic             start_ok;

  // The limit-register read path of the FIFO is never used.
  assign fifo_rd_reg = 1'b0;

  assign fifo_rd_enb = rd_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign byte_done   = done_q;

  // Next-state, counter and datapath logic; outputs are derived from the
  // next state so each registered output lines up with its state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;

    bit_end  = (cnt_q == CNT_LAST);
    start_ok = tx_en & ~fifo_empty;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // Read data is valid exactly one cycle after the strobe.
        shift_d   = fifo_data;
        parity_d  = ^fifo_data;
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        state_d   = S_START;
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d     = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          // Wraps 7 -> 0 naturally when leaving the data phase.
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = S_PARITY;
            end else begin
              state_d = S_STOP;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Go straight to the next read to keep the inter-frame gap at 2.
          if (start_ok) begin
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase

    rd_d   = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four instances with different bit periods and
// parity settings, each fed by a queue-based FIFO model. Bytes written into
// the FIFO model are pushed to a scoreboard; a line monitor records each
// frame as it appears on tx and compares it with a waveform built from the
// byte by the UART framing rules.
module tb_fifo_uart_tx;

  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input bit ok,
                     input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NB; gi++) begin : g_cfg
    localparam int CPB  = (gi == 0 || gi == 1) ? 4 : ((gi == 2) ? 2 : 3);
    localparam int PAR  = (gi == 1 || gi == 3) ? 1 : 0;
    localparam int FLEN = CPB * ((PAR != 0) ? 11 : 10);

    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       rd, rd_reg, tx, busy, done;

    logic [7:0] q[$];
    logic [7:0] sb[$];
    bit         fin = 1'b0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(PAR)) dut (
      .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
      .fifo_data(fifo_data), .fifo_rd_enb(rd), .fifo_rd_reg(rd_reg),
      .tx(tx), .busy(busy), .byte_done(done)
    );

    // FIFO model: registered read data, zero when no read is in progress.
    always @(posedge clk) begin
      if (rd === 1'b1) begin
        chk($sformatf("blk%0d read while empty", gi), q.size() != 0, q.size(), 1);
        if (q.size() != 0) fifo_data <= q.pop_front();
        else fifo_data <= 8'h00;
      end else begin
        fifo_data <= 8'h00;
      end
    end

    always @(negedge clk) fifo_empty = (q.size() == 0);

    // Line monitor state.
    int          cyc = 0, reads = 0, retired = 0, dones = 0;
    int          last_rd_cyc = -100, end_cyc = -100, pos = 0;
    bit          in_frame = 1'b0, gap = 1'b0, follow = 1'b0, prev_rd = 1'b0;
    logic [63:0] wave, dwave, bwave;

    always @(negedge clk) begin : mon
      logic [7:0]  b;
      logic [63:0] ew, ed, eb;
      int          bn;
      cyc++;
      if (rst === 1'b1) begin
        in_frame = 1'b0;
        gap      = 1'b0;
        follow   = 1'b0;
        // Bytes already read but not yet sent are lost with the frame.
        while (reads > retired) begin
          if (sb.size() != 0) void'(sb.pop_front());
          retired++;
        end
      end else begin
        chk($sformatf("blk%0d fifo_rd_reg", gi), rd_reg === 1'b0, rd_reg, 0);
        if (rd === 1'b1) begin
          chk($sformatf("blk%0d read during frame", gi), !in_frame, in_frame, 0);
          chk($sformatf("blk%0d read strobe width", gi), !prev_rd, prev_rd, 0);
          reads++;
          last_rd_cyc = cyc;
        end
        if (gap) begin
          chk($sformatf("blk%0d busy after stop", gi), busy === rd, busy, rd);
          follow = (rd === 1'b1);
          gap    = 1'b0;
        end
        if (!in_frame) begin
          if (tx === 1'b0) begin
            in_frame = 1'b1;
            pos      = 0;
            wave     = '0;
            dwave    = '0;
            bwave    = '0;
            chk($sformatf("blk%0d read to start", gi), cyc - last_rd_cyc == 2,
                cyc - last_rd_cyc, 2);
            if (follow) begin
              chk($sformatf("blk%0d stop to next start", gi), cyc - end_cyc == 3,
                  cyc - end_cyc, 3);
            end
            follow = 1'b0;
          end else begin
            chk($sformatf("blk%0d byte_done outside frame", gi), done === 1'b0, done, 0);
          end
        end
        if (in_frame) begin
          wave[pos]  = tx;
          dwave[pos] = done;
          bwave[pos] = busy;
          if (done === 1'b1) dones++;
          pos++;
          if (pos == FLEN) begin
            chk($sformatf("blk%0d frame expected", gi), sb.size() != 0, sb.size(), 1);
            b  = (sb.size() != 0) ? sb.pop_front() : 8'h00;
            ew = '0;
            ed = '0;
            eb = '0;
            for (int k = 0; k < FLEN; k++) begin
              bn = k / CPB;
              if (bn == 0) ew[k] = 1'b0;
              else if (bn <= 8) ew[k] = b[bn-1];
              else if (PAR != 0 && bn == 9) ew[k] = ($countones(b) % 2 == 1);
              else ew[k] = 1'b1;
              eb[k] = 1'b1;
            end
            ed[FLEN-1] = 1'b1;
            chk($sformatf("blk%0d tx wave byte 0x%02h", gi, b), wave === ew, wave, ew);
            chk($sformatf("blk%0d byte_done wave byte 0x%02h", gi, b), dwave === ed, dwave, ed);
            chk($sformatf("blk%0d busy wave byte 0x%02h", gi, b), bwave === eb, bwave, eb);
            $display("blk%0d frame byte 0x%02h at cycle %0d", gi, b, cyc);
            in_frame = 1'b0;
            gap      = 1'b1;
            end_cyc  = cyc;
            retired++;
          end
        end
      end
      prev_rd = (rd === 1'b1) && (rst !== 1'b1);
    end

    task automatic push(input logic [7:0] b);
      q.push_back(b);
      sb.push_back(b);
    endtask

    task automatic wait_drain(input int maxc, input string what);
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (n < maxc && !(q.size() == 0 && busy === 1'b0 && !in_frame));
      chk($sformatf("blk%0d %s drain timeout", gi, what), n < maxc, n, maxc);
    endtask

    task automatic wait_frame(input string what);
      int n = 0;
      while (!in_frame && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("blk%0d %s frame start timeout", gi, what), n < 200, n, 200);
    endtask

    initial begin : stim
      int base, dbase, bad, n;
      // Reset state.
      @(negedge clk);
      chk($sformatf("blk%0d reset outputs", gi), {tx, busy, done, rd, rd_reg} === 5'b10000,
          {tx, busy, done, rd, rd_reg}, 5'b10000);
      rst = 1'b0;

      // Enabled but empty: the line stays idle.
      tx_en = 1'b1;
      bad = 0;
      repeat (100) begin
        @(negedge clk);
        if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk($sformatf("blk%0d idle with empty fifo", gi), bad == 0, bad, 0);

      // Single byte.
      base = reads;
      push((gi == 0) ? 8'hA5 : 8'($urandom));
      wait_drain(FLEN * 3 + 20, "single");
      chk($sformatf("blk%0d single read count", gi), reads - base == 1, reads - base, 1);

      // Back-to-back pair with known parity.
      base = reads;
      push(8'h07);
      push(8'h00);
      wait_drain(FLEN * 4 + 40, "pair");
      chk($sformatf("blk%0d pair read count", gi), reads - base == 2, reads - base, 2);

      // Drop tx_en mid-frame with three bytes queued.
      tx_en = 1'b0;
      repeat (3) push(8'($urandom));
      repeat (2) @(negedge clk);
      base = reads;
      tx_en = 1'b1;
      wait_frame("tx_en drop");
      repeat (3 * CPB) @(negedge clk);
      tx_en = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < FLEN * 3) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("blk%0d tx_en drop finish timeout", gi), n < FLEN * 3, n, FLEN * 3);
      repeat (20) @(negedge clk);
      chk($sformatf("blk%0d tx_en drop read count", gi), reads - base == 1, reads - base, 1);
      chk($sformatf("blk%0d tx_en drop idle", gi), {busy, tx} === 2'b01, {busy, tx}, 2'b01);
      chk($sformatf("blk%0d tx_en drop fifo left", gi), q.size() == 2, q.size(), 2);
      tx_en = 1'b1;
      wait_drain(FLEN * 4 + 40, "tx_en resume");

      // Reset in the middle of the data bits.
      tx_en = 1'b0;
      repeat (2) push(8'($urandom));
      repeat (2) @(negedge clk);
      base = reads;
      tx_en = 1'b1;
      wait_frame("reset");
      repeat (4 * CPB) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk($sformatf("blk%0d mid-frame reset outputs", gi), {tx, busy, done, rd} === 4'b1000,
          {tx, busy, done, rd}, 4'b1000);
      @(negedge clk);
      rst = 1'b0;
      wait_drain(FLEN * 3 + 40, "after reset");
      chk($sformatf("blk%0d reset read count", gi), reads - base == 2, reads - base, 2);

      // Sixteen bytes back to back until the FIFO runs dry.
      base  = reads;
      dbase = dones;
      repeat (16) push(8'($urandom));
      wait_drain(16 * (FLEN + 2) + 50, "burst");
      chk($sformatf("blk%0d burst read count", gi), reads - base == 16, reads - base, 16);
      chk($sformatf("blk%0d burst byte_done count", gi), dones - dbase == 16, dones - dbase, 16);
      chk($sformatf("blk%0d scoreboard empty", gi), sb.size() == 0, sb.size(), 0);

      fin = 1'b1;
    end
  end

  initial begin : top
    int t = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) && t < 50000) begin
      @(negedge clk);
      t++;
    end
    chk("all blocks finished", t < 50000, t, 50000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
